slice_scheduler: RTL



---
 rtl/display_pkg.sv | 28 ++
 rtl/slice_scheduler_col_seek.sv | 24 ++
 rtl/slice_scheduler.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the rotating display pipeline.
package display_pkg;

  localparam int unsigned ROTATIONAL_RES = 1024;
  localparam int unsigned NUM_COLS       = 64;
  localparam int unsigned SCAN_RATE      = NUM_COLS / 2;
  localparam int unsigned RGB_RES        = 8;

  localparam logic [1:0] MODE_CYL    = 2'd0;
  localparam logic [1:0] MODE_SPHERE = 2'd1;
  localparam logic [1:0] MODE_CUBE   = 2'd2;
  localparam logic [1:0] MODE_BOIDS  = 2'd3;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEEK       = 3'd1,
    FETCH      = 3'd2,
    WAIT_READY = 3'd3,
    ISSUE      = 3'd4,
    DONE       = 3'd5
  } sched_state_t;

  // Saturating 16-bit increment used by the abort statistics counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/slice_scheduler_col_seek.sv
// col_seek: lowest set bit of a merged column mask at or above a start index.
module col_seek #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] en,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan high to low so the lowest qualifying index is the one left standing.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (en[i] && (IDX_W'(i) >= start)) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/slice_scheduler.sv
// slice_scheduler: walks enabled column pairs of each rotational slice and
// hands them to the hub75 driver. Optional macro SLICE_SCHED_STATS_EN enables
// the saturating overrun_count statistics counter (tied to 0 otherwise).
module slice_scheduler #(
  parameter int unsigned ROTATIONAL_RES = display_pkg::ROTATIONAL_RES,
  parameter int unsigned NUM_COLS       = display_pkg::NUM_COLS,
  parameter int unsigned SCAN_RATE      = display_pkg::SCAN_RATE,
  parameter int unsigned FETCH_LATENCY  = 2
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
  input  logic [NUM_COLS-1:0]            col_mask,
  input  logic [1:0]                     mode_in,
  input  logic                           hub75_ready,
  output logic [$clog2(SCAN_RATE)-1:0]   col_num1,
  output logic [$clog2(SCAN_RATE):0]     col_num2,
  output logic [1:0]                     mode_out,
  output logic                           data_valid,
  output logic                           slice_done,
  output logic                           busy,
  output logic                           overrun,
  output logic [15:0]                    overrun_count
);

  import display_pkg::*;

  localparam int unsigned TW = $clog2(ROTATIONAL_RES);
  localparam int unsigned CW = $clog2(SCAN_RATE);
  localparam int unsigned IW = CW + 1;
  localparam int unsigned FW = 4;

  localparam logic [2:0] ST_IDLE  = 3'(IDLE);
  localparam logic [2:0] ST_SEEK  = 3'(SEEK);
  localparam logic [2:0] ST_FETCH = 3'(FETCH);
  localparam logic [2:0] ST_WAIT  = 3'(WAIT_READY);
  localparam logic [2:0] ST_ISSUE = 3'(ISSUE);
  localparam logic [2:0] ST_DONE  = 3'(DONE);

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] theta_q, theta_d;
  logic [1:0]    mode_q, mode_d;
  logic [IW-1:0] start_q, start_d;
  logic [CW-1:0] col_q, col_d;
  logic [IW-1:0] col2_q, col2_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          dv_q, dv_d;
  logic          sd_q, sd_d;
  logic          busy_q, busy_d;
  logic          ovr_q, ovr_d;
`ifdef SLICE_SCHED_STATS_EN
  logic [15:0]   ovr_cnt_q, ovr_cnt_d;
`endif

  logic [SCAN_RATE-1:0] en;
  logic                 seek_found;
  logic [IW-1:0]        seek_idx;
  logic                 abort;

  // A pair is worth sending if either of its two columns has content.
  assign en    = col_mask[SCAN_RATE-1:0] | col_mask[2*SCAN_RATE-1:SCAN_RATE];
  assign abort = (dtheta != theta_q);

  col_seek #(
    .WIDTH (SCAN_RATE),
    .IDX_W (IW)
  ) u_col_seek (
    .en    (en),
    .start (start_q),
    .found (seek_found),
    .idx   (seek_idx)
  );

  // Next-state and next-output logic; abort preempts every active state.
  always_comb begin
    state_d = state_q;
    theta_d = theta_q;
    mode_d  = mode_q;
    start_d = start_q;
    col_d   = col_q;
    col2_d  = col2_q;
    cnt_d   = cnt_q;
    dv_d    = 1'b0;
    sd_d    = 1'b0;
    ovr_d   = ovr_q;
`ifdef SLICE_SCHED_STATS_EN
    ovr_cnt_d = ovr_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        theta_d = dtheta;
        mode_d  = mode_in;
        start_d = '0;
        state_d = ST_SEEK;
      end
      ST_SEEK, ST_FETCH, ST_WAIT, ST_ISSUE: begin
        if (abort) begin
          theta_d = dtheta;
          mode_d  = mode_in;
          start_d = '0;
          ovr_d   = 1'b1;
`ifdef SLICE_SCHED_STATS_EN
          ovr_cnt_d = sat_inc16(ovr_cnt_q);
`endif
          state_d = ST_SEEK;
        end else begin
          case (state_q)
            ST_SEEK: begin
              if (seek_found) begin
                col_d   = CW'(seek_idx);
                col2_d  = seek_idx + IW'(SCAN_RATE);
                cnt_d   = '0;
                state_d = ST_FETCH;
              end else begin
                sd_d    = 1'b1;
                state_d = ST_DONE;
              end
            end
            ST_FETCH: begin
              if (cnt_q == FW'(FETCH_LATENCY - 1)) begin
                state_d = ST_WAIT;
              end else begin
                cnt_d = cnt_q + FW'(1);
              end
            end
            ST_WAIT: begin
              if (hub75_ready) begin
                dv_d    = 1'b1;
                state_d = ST_ISSUE;
              end
            end
            default: begin
              start_d = IW'(col_q) + IW'(1);
              state_d = ST_SEEK;
            end
          endcase
        end
      end
      ST_DONE: begin
        if (abort) begin
          theta_d = dtheta;
          mode_d  = mode_in;
          start_d = '0;
          state_d = ST_SEEK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SEEK) || (state_d == ST_FETCH) ||
             (state_d == ST_WAIT) || (state_d == ST_ISSUE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      theta_q <= '0;
      mode_q  <= MODE_CYL;
      start_q <= '0;
      col_q   <= '0;
      col2_q  <= IW'(SCAN_RATE);
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      sd_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SLICE_SCHED_STATS_EN
      ovr_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      theta_q <= theta_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      col_q   <= col_d;
      col2_q  <= col2_d;
      cnt_q   <= cnt_d;
      dv_q    <= dv_d;
      sd_q    <= sd_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
`ifdef SLICE_SCHED_STATS_EN
      ovr_cnt_q <= ovr_cnt_d;
`endif
    end
  end

  assign col_num1   = col_q;
  assign col_num2   = col2_q;
  assign mode_out   = mode_q;
  assign data_valid = dv_q;
  assign slice_done = sd_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;
`ifdef SLICE_SCHED_STATS_EN
  assign overrun_count = ovr_cnt_q;
`else
  assign overrun_count = 16'd0;
`endif

endmodule
